// File: rtl/apb_demux_addr_tmo_pkg.sv
// Shared types for the address-decoding APB demultiplexer: FSM states,
// default APB/rule structs and the decode-error response.
package apb_demux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DECERR
  } state_e;

  // xbar-style address rule: addresses in [start_addr, end_addr) map to idx
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } xbar_rule_32_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

  localparam apb_resp_t ERR_RESP = '{pready: 1'b1, prdata: '0, pslverr: 1'b1};

endpackage

// File: rtl/apb_demux_addr_tmo_decode.sv
// Address-map decoder: highest matching rule wins; no match or an index
// beyond the available ports is reported as a decode error.
module apb_demux_addr_tmo_decode
  import apb_demux_pkg::*;
#(
  parameter int unsigned NoIndices   = 2,
  parameter int unsigned NoRules     = 2,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned SelectWidth = 1,
  parameter type         rule_t      = xbar_rule_32_t
) (
  input  logic [AddrWidth-1:0]   addr_i,
  input  rule_t                  addr_map_i [NoRules],
  output logic [SelectWidth-1:0] idx_o,
  output logic                   dec_error_o
);

  logic        match;
  logic [31:0] match_idx;

  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int unsigned r = 0; r < NoRules; r++) begin
      if ((addr_i >= addr_map_i[r].start_addr) && (addr_i < addr_map_i[r].end_addr)) begin
        match     = 1'b1;
        match_idx = 32'(addr_map_i[r].idx);
      end
    end
    dec_error_o = !match || (match_idx >= 32'(NoIndices));
    idx_o       = SelectWidth'(match_idx);
  end

endmodule

// File: rtl/apb_demux_addr_tmo.sv
// APB demultiplexer routed by an address map, with decode-error FSM.
// Optional ACCESS-phase watchdog enabled by APB_DEMUX_ADDR_TMO_TIMEOUT_EN.
module apb_demux_addr_tmo
  import apb_demux_pkg::*;
#(
  parameter int unsigned NoMstPorts    = 2,
  parameter int unsigned NoRules       = 2,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TimeoutCycles = 256,
  parameter type         rule_t        = xbar_rule_32_t,
  parameter type         req_t         = apb_req_t,
  parameter type         resp_t        = apb_resp_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o,
  output req_t  mst_req_o  [NoMstPorts],
  input  resp_t mst_resp_i [NoMstPorts],
  input  rule_t addr_map_i [NoRules],
  output logic  timeout_o
);

  localparam int unsigned SelectWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

  state_e                 state_q, state_d;
  logic [SelectWidth-1:0] sel_q, sel_d;
  logic [SelectWidth-1:0] dec_idx;
  logic                   dec_error;

  apb_demux_addr_tmo_decode #(
    .NoIndices  (NoMstPorts),
    .NoRules    (NoRules),
    .AddrWidth  (AddrWidth),
    .SelectWidth(SelectWidth),
    .rule_t     (rule_t)
  ) i_decode (
    .addr_i     (slv_req_i.paddr),
    .addr_map_i (addr_map_i),
    .idx_o      (dec_idx),
    .dec_error_o(dec_error)
  );

`ifdef APB_DEMUX_ADDR_TMO_TIMEOUT_EN
  localparam int unsigned          CntWidth = $clog2(TimeoutCycles);
  localparam logic [CntWidth-1:0]  TmoLast  = CntWidth'(TimeoutCycles - 1);

  logic [CntWidth-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    timeout_o  = 1'b0;
    slv_resp_o = '0;
    for (int unsigned i = 0; i < NoMstPorts; i++) begin
      mst_req_o[i]         = slv_req_i;
      mst_req_o[i].psel    = 1'b0;
      mst_req_o[i].penable = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (slv_req_i.psel && !slv_req_i.penable) begin
          sel_d = dec_idx;
          if (dec_error) begin
            state_d = DECERR;
          end else begin
            state_d = ACCESS;
            for (int unsigned i = 0; i < NoMstPorts; i++) begin
              if (SelectWidth'(i) == dec_idx) mst_req_o[i].psel = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        if (!slv_req_i.psel) begin
          state_d = IDLE;
        end else begin
          for (int unsigned i = 0; i < NoMstPorts; i++) begin
            if (SelectWidth'(i) == sel_q) begin
              mst_req_o[i].psel    = 1'b1;
              mst_req_o[i].penable = slv_req_i.penable;
              slv_resp_o           = mst_resp_i[i];
            end
          end
          if (slv_resp_o.pready) begin
            state_d = IDLE;
          end
`ifdef APB_DEMUX_ADDR_TMO_TIMEOUT_EN
          // A real pready in the last allowed cycle takes precedence over the abort
          else if (tmo_cnt_q == TmoLast) begin
            for (int unsigned i = 0; i < NoMstPorts; i++) begin
              mst_req_o[i].psel    = 1'b0;
              mst_req_o[i].penable = 1'b0;
            end
            slv_resp_o = ERR_RESP;
            timeout_o  = 1'b1;
            state_d    = IDLE;
          end
`endif
        end
      end
      DECERR: begin
        state_d = IDLE;
        if (slv_req_i.psel) slv_resp_o = ERR_RESP;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef APB_DEMUX_ADDR_TMO_TIMEOUT_EN
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != ACCESS) begin
      tmo_cnt_d = '0;
    end else if (!slv_resp_o.pready && (tmo_cnt_q != TmoLast)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_cnt_q <= '0;
    else         tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_apb_demux_addr_tmo.sv
// Directed bench for apb_demux_addr_tmo (two ports, two rules, 8-cycle watchdog).
module tb_apb_demux_addr_tmo;
  import apb_demux_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  apb_req_t      slv_req;
  apb_resp_t     slv_resp;
  apb_req_t      mst_req  [2];
  apb_resp_t     mst_resp [2];
  xbar_rule_32_t addr_map [2];
  logic          tmo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_demux_addr_tmo #(
    .NoMstPorts   (2),
    .NoRules      (2),
    .AddrWidth    (32),
    .TimeoutCycles(8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .slv_req_i (slv_req),
    .slv_resp_o(slv_resp),
    .mst_req_o (mst_req),
    .mst_resp_i(mst_resp),
    .addr_map_i(addr_map),
    .timeout_o (tmo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    slv_req.paddr   = addr;
    slv_req.pwrite  = wr;
    slv_req.pwdata  = wdata;
    slv_req.pstrb   = 4'hF;
    slv_req.psel    = 1'b1;
    slv_req.penable = 1'b0;
  endtask

  task automatic set_map(input logic [31:0] s0, input logic [31:0] e0, input logic [31:0] i0,
                         input logic [31:0] s1, input logic [31:0] e1, input logic [31:0] i1);
    addr_map[0] = '{idx: i0, start_addr: s0, end_addr: e0};
    addr_map[1] = '{idx: i1, start_addr: s1, end_addr: e1};
  endtask

  initial begin
    rst_n       = 1'b0;
    slv_req     = '0;
    mst_resp[0] = '0;
    mst_resp[1] = '0;
    set_map(32'h0, 32'h1000, 32'd0, 32'h1000, 32'h2000, 32'd1);

    @(negedge clk);
    chk("rst_resp", 64'(slv_resp), 64'h0);
    chk("rst_psel", {mst_req[1].psel, mst_req[0].psel}, 64'h0);
    chk("rst_tmo", 64'(tmo), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // write 0x1004 -> port1 with two wait states
    setup(32'h1004, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_setup_psel", {mst_req[1].psel, mst_req[1].penable, mst_req[0].psel}, 64'h4);
    chk("wr_bcast_wdata", 64'(mst_req[0].pwdata), 64'hDEADBEEF);
    step();
    slv_req.penable = 1'b1;
    @(negedge clk);
    chk("wr_acc1_psel", {mst_req[1].psel, mst_req[1].penable, mst_req[0].psel}, 64'h6);
    chk("wr_acc1_ready", 64'(slv_resp.pready), 64'h0);
    step();
    @(negedge clk);
    chk("wr_acc2_ready", 64'(slv_resp.pready), 64'h0);
    chk("wr_acc2_p0", 64'(mst_req[0].psel), 64'h0);
    step();
    mst_resp[1] = '{pready: 1'b1, prdata: 32'h0, pslverr: 1'b0};
    @(negedge clk);
    chk("wr_acc3_resp", {slv_resp.pready, slv_resp.pslverr}, 64'h2);
    step();
    slv_req     = '0;
    mst_resp[1] = '0;
    @(negedge clk);
    chk("wr_idle_psel", {mst_req[1].psel, mst_req[0].psel}, 64'h0);
    chk("wr_idle_resp", 64'(slv_resp), 64'h0);

    // unmapped read
    step();
    setup(32'h3000, 1'b0, 32'h0);
    @(negedge clk);
    chk("decerr_setup_psel", {mst_req[1].psel, mst_req[0].psel}, 64'h0);
    step();
    slv_req.penable = 1'b1;
    @(negedge clk);
    chk("decerr_resp", 64'(slv_resp), {30'h0, 1'b1, 32'h0, 1'b1});
    chk("decerr_psel", {mst_req[1].psel, mst_req[0].psel}, 64'h0);
    step();
    slv_req = '0;

    // overlapping rules, higher index wins; map change mid-access is ignored
    set_map(32'h0, 32'h2000, 32'd0, 32'h1000, 32'h2000, 32'd1);
    step();
    setup(32'h1800, 1'b0, 32'h0);
    @(negedge clk);
    chk("ovl_setup_psel", {mst_req[1].psel, mst_req[0].psel}, 64'h2);
    step();
    slv_req.penable = 1'b1;
    set_map(32'h0, 32'h2000, 32'd0, 32'h3000, 32'h4000, 32'd1);
    @(negedge clk);
    chk("ovl_hold_sel", {mst_req[1].psel, mst_req[0].psel}, 64'h2);
    step();
    mst_resp[1] = '{pready: 1'b1, prdata: 32'h12345678, pslverr: 1'b0};
    @(negedge clk);
    chk("ovl_rdata", 64'(slv_resp.prdata), 64'h12345678);
    step();
    slv_req     = '0;
    mst_resp[1] = '0;
    set_map(32'h0, 32'h1000, 32'd0, 32'h1000, 32'h2000, 32'd1);

    // back-to-back reads, no idle cycle between them
    step();
    setup(32'h0010, 1'b0, 32'h0);
    @(negedge clk);
    chk("b2b_a_psel", {mst_req[1].psel, mst_req[0].psel}, 64'h1);
    step();
    slv_req.penable = 1'b1;
    mst_resp[0]     = '{pready: 1'b1, prdata: 32'hA5A5A5A5, pslverr: 1'b0};
    @(negedge clk);
    chk("b2b_a_rdata", {slv_resp.pready, slv_resp.prdata}, {1'b1, 32'hA5A5A5A5});
    step();
    setup(32'h1010, 1'b0, 32'h0);
    @(negedge clk);
    chk("b2b_b_setup_psel", {mst_req[1].psel, mst_req[1].penable, mst_req[0].psel}, 64'h4);
    chk("b2b_b_setup_ready", 64'(slv_resp.pready), 64'h0);
    step();
    slv_req.penable = 1'b1;
    mst_resp[0]     = '0;
    mst_resp[1]     = '{pready: 1'b1, prdata: 32'h5A5A5A5A, pslverr: 1'b0};
    @(negedge clk);
    chk("b2b_b_rdata", {slv_resp.pready, slv_resp.prdata}, {1'b1, 32'h5A5A5A5A});
    step();
    slv_req     = '0;
    mst_resp[1] = '0;

    // port0 never ready
    step();
    setup(32'h0020, 1'b0, 32'h0);
    step();
    slv_req.penable = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("stuck_cyc%0d", k), {tmo, slv_resp.pready, mst_req[0].psel}, 64'h1);
      step();
    end
    @(negedge clk);
`ifdef APB_DEMUX_ADDR_TMO_TIMEOUT_EN
    chk("tmo_pulse", 64'(tmo), 64'h1);
    chk("tmo_resp", {slv_resp.pready, slv_resp.pslverr, slv_resp.prdata}, {2'b11, 32'h0});
    chk("tmo_psel", {mst_req[1].psel, mst_req[0].psel}, 64'h0);
    step();
    slv_req = '0;
    @(negedge clk);
    chk("tmo_after", 64'(tmo), 64'h0);
`else
    chk("notmo_cyc8", {tmo, slv_resp.pready, mst_req[0].psel}, 64'h1);
    step();
    mst_resp[0] = '{pready: 1'b1, prdata: 32'h0BADF00D, pslverr: 1'b0};
    @(negedge clk);
    chk("notmo_late_ready", {tmo, slv_resp.pready, slv_resp.prdata}, {2'b01, 32'h0BADF00D});
    step();
    slv_req     = '0;
    mst_resp[0] = '0;
`endif
    step();
    setup(32'h1000, 1'b1, 32'h11);
    @(negedge clk);
    chk("post_stuck_psel", {mst_req[1].psel, mst_req[0].psel}, 64'h2);
    step();
    slv_req.penable = 1'b1;
    mst_resp[1]     = '{pready: 1'b1, prdata: 32'h0, pslverr: 1'b0};
    @(negedge clk);
    chk("post_stuck_resp", {slv_resp.pready, slv_resp.pslverr}, 64'h2);
    step();
    slv_req     = '0;
    mst_resp[1] = '0;

    // upstream drops psel mid-access
    step();
    setup(32'h1100, 1'b0, 32'h0);
    step();
    slv_req.penable = 1'b1;
    #1;
    slv_req.psel = 1'b0;
    #1;
    chk("drop_psel", {mst_req[1].psel, mst_req[0].psel}, 64'h0);
    step();
    setup(32'h0100, 1'b0, 32'h0);
    @(negedge clk);
    chk("drop_next_psel", {mst_req[1].psel, mst_req[0].psel}, 64'h1);
    step();
    slv_req = '0;

    // reset during the second ACCESS cycle
    step();
    setup(32'h0040, 1'b0, 32'h0);
    step();
    slv_req.penable = 1'b1;
    step();
    rst_n       = 1'b0;
    mst_resp[0] = '{pready: 1'b1, prdata: 32'hCAFE, pslverr: 1'b0};
    #1;
    chk("rst_mid_psel", {mst_req[1].psel, mst_req[0].psel}, 64'h0);
    chk("rst_mid_ready", 64'(slv_resp.pready), 64'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_idle", {slv_resp.pready, mst_req[0].psel}, 64'h0);
    step();
    slv_req     = '0;
    mst_resp[0] = '0;
    step();
    setup(32'h0044, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst_rel_setup", {mst_req[1].psel, mst_req[0].psel, mst_req[0].penable}, 64'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
